perf_snapshot: RTL and testbench

PERF_SNAPSHOT -- requirements
Module: perf_snapshot

---
 rtl/perf_snapshot.sv | 152 +++++++++++++++
 tb/tb_perf_snapshot.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_snapshot.sv
// ============================================================================
// Module      : perf_snapshot
// Description : Captures three live performance counters atomically and sends
//               them as a byte frame over a valid/ready stream. Defining
//               PERF_SNAPSHOT_CHECKSUM_EN appends an XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_snapshot #(
    parameter logic [7:0] SYNC_WORD = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] instruction_count,
    input  logic [19:0] memory_access_count,
    input  logic [19:0] memory_correction_count,
    input  logic        snap_req,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        snap_busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
`ifdef PERF_SNAPSHOT_CHECKSUM_EN
    localparam logic [1:0] c_CSUM = 2'd2;
`endif
    localparam logic [3:0] c_LAST_IDX = 4'd9;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [19:0] r_instr;
    logic [19:0] r_access;
    logic [19:0] r_corr;
    logic [3:0]  r_idx;
    logic [7:0]  w_byte;
    logic        w_xfer;
    logic        w_last_data;
`ifdef PERF_SNAPSHOT_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign w_xfer      = out_valid & out_ready;
    assign w_last_data = (r_idx == c_LAST_IDX);

    // Frame bytes: sync, then each count zero-extended to 24 bits, LSB first
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            4'd0:    w_byte = SYNC_WORD;
            4'd1:    w_byte = r_instr[7:0];
            4'd2:    w_byte = r_instr[15:8];
            4'd3:    w_byte = {4'h0, r_instr[19:16]};
            4'd4:    w_byte = r_access[7:0];
            4'd5:    w_byte = r_access[15:8];
            4'd6:    w_byte = {4'h0, r_access[19:16]};
            4'd7:    w_byte = r_corr[7:0];
            4'd8:    w_byte = r_corr[15:8];
            4'd9:    w_byte = {4'h0, r_corr[19:16]};
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_data     = 8'h00;
        case (r_state)
            c_IDLE: begin
                if (snap_req) begin
                    w_next_state = c_SEND;
                end
            end
            c_SEND: begin
                out_valid = 1'b1;
                out_data  = w_byte;
`ifdef PERF_SNAPSHOT_CHECKSUM_EN
                if (out_ready && w_last_data) begin
                    w_next_state = c_CSUM;
                end
`else
                out_last = w_last_data;
                if (out_ready && w_last_data) begin
                    w_next_state = c_IDLE;
                end
`endif
            end
`ifdef PERF_SNAPSHOT_CHECKSUM_EN
            c_CSUM: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = r_csum;
                if (out_ready) begin
                    w_next_state = c_IDLE;
                end
            end
`endif
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    assign snap_busy = out_valid;

    // Shadow capture happens only on the IDLE->SEND edge, so later count
    // changes and mid-frame requests cannot disturb the frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr  <= 20'h0;
            r_access <= 20'h0;
            r_corr   <= 20'h0;
            r_idx    <= 4'd0;
        end else if (r_state == c_IDLE) begin
            r_idx <= 4'd0;
            if (snap_req) begin
                r_instr  <= instruction_count;
                r_access <= memory_access_count;
                r_corr   <= memory_correction_count;
            end
        end else if (r_state == c_SEND && w_xfer) begin
            r_idx <= w_last_data ? 4'd0 : r_idx + 4'd1;
        end
    end

`ifdef PERF_SNAPSHOT_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum <= 8'h00;
        end else if (r_state == c_IDLE) begin
            r_csum <= 8'h00;
        end else if (r_state == c_SEND && w_xfer) begin
            r_csum <= r_csum ^ w_byte;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_perf_snapshot.sv
// ============================================================================
// Module      : tb_perf_snapshot
// Description : Directed self-checking bench for perf_snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_perf_snapshot;

    logic        clk;
    logic        reset;
    logic [19:0] instruction_count;
    logic [19:0] memory_access_count;
    logic [19:0] memory_correction_count;
    logic        snap_req;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        snap_busy;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PERF_SNAPSHOT_CHECKSUM_EN
    localparam int c_NBYTES = 11;
`else
    localparam int c_NBYTES = 10;
`endif
    logic [7:0] r_exp [0:10];

    perf_snapshot #(.SYNC_WORD(8'hA5)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .instruction_count       (instruction_count),
        .memory_access_count     (memory_access_count),
        .memory_correction_count (memory_correction_count),
        .snap_req                (snap_req),
        .out_ready               (out_ready),
        .out_valid               (out_valid),
        .out_data                (out_data),
        .out_last                (out_last),
        .snap_busy               (snap_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, ".busy"},  {31'h0, snap_busy}, 32'h0);
        check({tag, ".last"},  {31'h0, out_last},  32'h0);
        check({tag, ".data"},  {24'h0, out_data},  32'h0);
    endtask

    task automatic check_byte(input int i);
        check($sformatf("b%0d.valid", i), {31'h0, out_valid}, 32'h1);
        check($sformatf("b%0d.busy", i),  {31'h0, snap_busy}, 32'h1);
        check($sformatf("b%0d.data", i),  {24'h0, out_data},  {24'h0, r_exp[i]});
        check($sformatf("b%0d.last", i),  {31'h0, out_last},
              (i == c_NBYTES - 1) ? 32'h1 : 32'h0);
    endtask

    task automatic set_counts();
        instruction_count       = 20'h12345;
        memory_access_count     = 20'h00ABC;
        memory_correction_count = 20'hFFFFF;
    endtask

    // Called at a negedge: one-cycle request pulse, returns at the negedge after capture
    task automatic capture(input bit hold_req);
        snap_req = 1'b1;
        @(negedge clk);
        if (!hold_req) snap_req = 1'b0;
    endtask

    // Walks the whole frame from the current negedge; stall_mode inserts two
    // not-ready cycles before every byte after the first
    task automatic run_frame(input bit stall_mode, input bit mid_req, input bit zero_counts);
        if (zero_counts) begin
            instruction_count       = 20'h0;
            memory_access_count     = 20'h0;
            memory_correction_count = 20'h0;
        end
        for (int i = 0; i < c_NBYTES; i++) begin
            snap_req = (mid_req && i == 3);
            if (stall_mode && i > 0) begin
                for (int s = 0; s < 2; s++) begin
                    out_ready = 1'b0;
                    check_byte(i);
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            check_byte(i);
            @(negedge clk);
        end
        snap_req = 1'b0;
    endtask

    initial begin
        r_exp[0] = 8'hA5; r_exp[1] = 8'h45; r_exp[2] = 8'h23; r_exp[3] = 8'h01;
        r_exp[4] = 8'hBC; r_exp[5] = 8'h0A; r_exp[6] = 8'h00; r_exp[7] = 8'hFF;
        r_exp[8] = 8'hFF; r_exp[9] = 8'h0F; r_exp[10] = 8'h7B;

        reset = 1'b0;
        snap_req = 1'b0;
        out_ready = 1'b1;
        instruction_count = 20'h0;
        memory_access_count = 20'h0;
        memory_correction_count = 20'h0;
        #2;
        check_idle("reset");
        // A request during reset must be ignored
        snap_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle("req_in_reset");
        snap_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Basic frame, ready always high
        set_counts();
        capture(1'b0);
        run_frame(1'b0, 1'b0, 1'b0);
        check_idle("basic_end");
        @(negedge clk);

        // Stalled frame
        capture(1'b0);
        run_frame(1'b1, 1'b0, 1'b0);
        check_idle("stall_end");
        @(negedge clk);

        // Counts cleared right after capture
        capture(1'b0);
        run_frame(1'b0, 1'b0, 1'b1);
        check_idle("zero_end");
        set_counts();
        @(negedge clk);

        // Mid-frame request ignored, nothing queued
        capture(1'b0);
        run_frame(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check_idle("no_requeue");
            @(negedge clk);
        end

        // Asynchronous reset after the 4th byte transfers
        capture(1'b0);
        for (int i = 0; i < 4; i++) begin
            check_byte(i);
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        check_idle("async_abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("abort_idle");
        capture(1'b0);
        run_frame(1'b0, 1'b0, 1'b0);
        check_idle("fresh_end");
        @(negedge clk);

        // Held request: back-to-back frames with one idle cycle between
        capture(1'b1);
        run_frame(1'b0, 1'b0, 1'b0);
        snap_req = 1'b1;
        check_idle("gap");
        @(negedge clk);
        snap_req = 1'b0;
        run_frame(1'b0, 1'b0, 1'b0);
        check_idle("b2b_end");
        @(negedge clk);
        check_idle("b2b_quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
